// File: rtl/audio_sched_pkg.sv
// rtl/audio_sched_pkg.sv - shared constants, FSM state type and arbitration helper for audio_sample_scheduler
//
// Contents:
//   DEF_WIDTH / DEF_DIV / DEF_GUARD : default sample width, period length, guard length
//   sched_state_t                   : scheduler FSM states
//   rr_pick()                       : two-way round-robin winner index
package audio_sched_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIV   = 1042;   // 50 MHz / 48 kHz
    localparam int DEF_GUARD = 4;

    typedef enum logic [1:0] {
        S_OPEN   = 2'd0,   // nothing staged, acceptance window open
        S_STAGED = 2'd1,   // one word held for the next tick
        S_GUARD  = 2'd2    // window closed with nothing staged
    } sched_state_t;

    // Single requester wins outright; on contention the requester that
    // did not win last time is chosen.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
        logic pick;
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_grant;
            default: pick = 1'b0;
        endcase
        return pick;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - sample period counter with tick, pre-tick and guard-window flags
//
// Ports:
//   inclk    : system clock, posedge
//   rst_n    : asynchronous active-low reset
//   tick     : high in the cycle the counter sits at DIV-1
//   pre_tick : high in the cycle the counter sits at DIV-2
//   guard    : high while the counter is in the last GUARD cycles (tick included)
module sample_tick_gen
    import audio_sched_pkg::*;
#(
    parameter int DIV   = DEF_DIV,
    parameter int GUARD = DEF_GUARD
) (
    input  logic inclk,
    input  logic rst_n,
    output logic tick,
    output logic pre_tick,
    output logic guard
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_PRE    = CW'(DIV - 2);
    localparam logic [CW-1:0] CNT_GSTART = CW'(DIV - GUARD);

    logic [CW-1:0] cnt;

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // All flags decode the registered count, so they are glitch-free
    // relative to the clock and zero while reset holds cnt at 0.
    assign tick     = (cnt == CNT_LAST);
    assign pre_tick = (cnt == CNT_PRE);
    assign guard    = (cnt >= CNT_GSTART);

endmodule

// File: rtl/audio_sample_scheduler.sv
// rtl/audio_sample_scheduler.sv - two-requester sample scheduler committing one word per sample period
//
// Ports:
//   inclk        : system clock, posedge
//   rst_n        : asynchronous active-low reset
//   req[1:0]     : requester r holds a word until ack[r]
//   data0, data1 : sample word of requester 0 / 1
//   ack[1:0]     : one-cycle pulse, word of requester r accepted
//   sample_tick  : one-cycle pulse per sample period
//   outdata      : committed sample, stable for a full period
//   out_src      : requester that supplied outdata
//   out_valid    : pulse with a tick that committed a new word
//   underrun     : pulse with a tick that found nothing staged
module audio_sample_scheduler
    import audio_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV   = DEF_DIV,
    parameter int GUARD = DEF_GUARD
) (
    input  logic             inclk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       ack,
    output logic             sample_tick,
    output logic [WIDTH-1:0] outdata,
    output logic             out_src,
    output logic             out_valid,
    output logic             underrun
);

    sched_state_t     state_q;
    sched_state_t     state_d;
    logic             last_grant_q;
    logic [WIDTH-1:0] stage_q;
    logic             stage_src_q;
    logic [WIDTH-1:0] outdata_q;
    logic             out_src_q;

    logic             tick;
    logic             pre_tick;
    logic             guard;

    logic             grant_idx;
    logic             accept;
    logic [WIDTH-1:0] sel_data;

    sample_tick_gen #(
        .DIV   (DIV),
        .GUARD (GUARD)
    ) u_tick_gen (
        .inclk    (inclk),
        .rst_n    (rst_n),
        .tick     (tick),
        .pre_tick (pre_tick),
        .guard    (guard)
    );

    // Arbitration: ack is one arbitration stage away from req; everything
    // else it depends on is registered. rst_n is folded in so ack stays
    // low while reset is held even if a requester is already high.
    always_comb begin
        grant_idx = rr_pick(req, last_grant_q);
        accept    = rst_n && (state_q == S_OPEN) && !guard && (req != 2'b00);
        sel_data  = grant_idx ? data1 : data0;
        ack       = 2'b00;
        if (accept) begin
            ack = grant_idx ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OPEN: begin
                if (accept) begin
                    state_d = S_STAGED;
                end else if (guard) begin
                    // With a one-cycle guard the window closes on the tick
                    // itself; the period is over, so go straight back to open.
                    state_d = tick ? S_OPEN : S_GUARD;
                end
            end
            S_STAGED: begin
                if (tick) begin
                    state_d = S_OPEN;
                end
            end
            S_GUARD: begin
                if (tick) begin
                    state_d = S_OPEN;
                end
            end
            default: state_d = S_OPEN;
        endcase
    end

    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_OPEN;
            last_grant_q <= 1'b1;
            stage_q      <= '0;
            stage_src_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                stage_q      <= sel_data;
                stage_src_q  <= grant_idx;
                last_grant_q <= grant_idx;
            end
        end
    end

    // The output register loads on the edge that enters the tick cycle, so
    // the new word is already visible alongside out_valid and then holds
    // for the whole following period. A word accepted in the pre-tick
    // cycle (only possible with a one-cycle guard) bypasses staging.
    always_ff @(posedge inclk or negedge rst_n) begin
        if (!rst_n) begin
            outdata_q <= '0;
            out_src_q <= 1'b0;
        end else if (pre_tick) begin
            if (state_q == S_STAGED) begin
                outdata_q <= stage_q;
                out_src_q <= stage_src_q;
            end else if (accept) begin
                outdata_q <= sel_data;
                out_src_q <= grant_idx;
            end
        end
    end

    assign sample_tick = tick;
    assign outdata     = outdata_q;
    assign out_src     = out_src_q;
    assign out_valid   = tick && (state_q == S_STAGED);
    assign underrun    = tick && (state_q != S_STAGED);

endmodule

// File: tb/tb_audio_sample_scheduler.sv
// tb/tb_audio_sample_scheduler.sv - scoreboard bench for audio_sample_scheduler
module tb_audio_sample_scheduler;

    localparam int W  = 16;
    localparam int DV = 16;
    localparam int GD = 4;

    logic         inclk;
    logic         rst_n;
    logic [1:0]   req;
    logic [W-1:0] data0;
    logic [W-1:0] data1;
    logic [1:0]   ack;
    logic         sample_tick;
    logic [W-1:0] outdata;
    logic         out_src;
    logic         out_valid;
    logic         underrun;

    audio_sample_scheduler #(
        .WIDTH (W),
        .DIV   (DV),
        .GUARD (GD)
    ) dut (
        .inclk       (inclk),
        .rst_n       (rst_n),
        .req         (req),
        .data0       (data0),
        .data1       (data1),
        .ack         (ack),
        .sample_tick (sample_tick),
        .outdata     (outdata),
        .out_src     (out_src),
        .out_valid   (out_valid),
        .underrun    (underrun)
    );

    initial inclk = 1'b0;
    always #5 inclk = ~inclk;

    typedef struct {
        logic [W-1:0] data;
        logic         src;
        logic         valid;
        logic         und;
    } tick_exp_t;

    typedef struct {
        logic [1:0] ack;
        int         cnt;
    } ack_exp_t;

    tick_exp_t tick_q[$];
    ack_exp_t  ack_q[$];
    tick_exp_t te;
    ack_exp_t  ae;

    int errors = 0;
    int checks = 0;
    int tb_cnt;

    // Bench-side period position, independent of the DUT counter.
    always @(posedge inclk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= 0;
        else        tb_cnt <= (tb_cnt == DV - 1) ? 0 : tb_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic tick_exp_t mk_tick(input logic [W-1:0] d, input logic s,
                                          input logic v, input logic u);
        tick_exp_t t;
        t.data = d; t.src = s; t.valid = v; t.und = u;
        return t;
    endfunction

    function automatic ack_exp_t mk_ack(input logic [1:0] a, input int c);
        ack_exp_t x;
        x.ack = a; x.cnt = c;
        return x;
    endfunction

    // Monitor: compares whenever the DUT presents an ack or a tick.
    always @(negedge inclk) begin
        if (rst_n === 1'b1) begin
            if (ack !== 2'b00) begin
                if (ack_q.size() == 0) begin
                    chk("ack_unexpected", {30'd0, ack}, 32'd0);
                end else begin
                    ae = ack_q.pop_front();
                    chk("ack_value", {30'd0, ack}, {30'd0, ae.ack});
                    chk("ack_cnt", tb_cnt, ae.cnt);
                end
            end
            if (sample_tick === 1'b1 || tb_cnt == DV - 1) begin
                if (tick_q.size() == 0) begin
                    chk("tick_queue_empty", 32'd0, 32'd1);
                end else begin
                    te = tick_q.pop_front();
                    chk("tick_present", {31'd0, sample_tick}, 32'd1);
                    chk("tick_cnt", tb_cnt, DV - 1);
                    chk("out_valid", {31'd0, out_valid}, {31'd0, te.valid});
                    chk("underrun", {31'd0, underrun}, {31'd0, te.und});
                    chk("outdata", {16'd0, outdata}, {16'd0, te.data});
                    chk("out_src", {31'd0, out_src}, {31'd0, te.src});
                end
            end
        end
    end

    task automatic at_cnt(input int k);
        int n;
        n = 0;
        do begin
            @(posedge inclk); #1;
            n++;
        end while (tb_cnt != k && n < 64);
        if (tb_cnt != k) chk("at_cnt_timeout", tb_cnt, k);
    endtask

    task automatic send(input int r, input logic [W-1:0] d, input int k);
        int n;
        at_cnt(k);
        if (r == 0) data0 = d; else data1 = d;
        req[r] = 1'b1;
        #1;
        n = 0;
        while (ack[r] !== 1'b1 && n < 64) begin
            @(posedge inclk); #1;
            n++;
        end
        if (ack[r] !== 1'b1) chk("send_ack_timeout", {31'd0, ack[r]}, 32'd1);
        @(posedge inclk); #1;
        req[r] = 1'b0;
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_ack"},      {30'd0, ack},         32'd0);
        chk({tag, "_tick"},     {31'd0, sample_tick}, 32'd0);
        chk({tag, "_outdata"},  {16'd0, outdata},     32'd0);
        chk({tag, "_out_src"},  {31'd0, out_src},     32'd0);
        chk({tag, "_valid"},    {31'd0, out_valid},   32'd0);
        chk({tag, "_underrun"}, {31'd0, underrun},    32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req   = 2'b00;
        data0 = '0;
        data1 = '0;
        repeat (3) @(posedge inclk);
        #1;
        req = 2'b01;
        #1;
        reset_outputs_zero("rst0");
        req = 2'b00;
        rst_n = 1'b1;

        // P0: single request mid-period, committed at the tick.
        tick_q.push_back(mk_tick(16'h1234, 1'b0, 1'b1, 1'b0));
        ack_q.push_back(mk_ack(2'b01, 2));
        send(0, 16'h1234, 2);

        // P1: request in the last open cycle, committed same period.
        at_cnt(DV - 1);
        tick_q.push_back(mk_tick(16'h4321, 1'b0, 1'b1, 1'b0));
        ack_q.push_back(mk_ack(2'b01, DV - GD - 1));
        send(0, 16'h4321, DV - GD - 1);

        // P2/P3: request raised in guard waits for the next period.
        at_cnt(DV - 1);
        tick_q.push_back(mk_tick(16'h4321, 1'b0, 1'b0, 1'b1));
        tick_q.push_back(mk_tick(16'h7777, 1'b1, 1'b1, 1'b0));
        ack_q.push_back(mk_ack(2'b10, 0));
        send(1, 16'h7777, DV - GD);

        // P4/P5: idle periods underrun and hold the last word.
        tick_q.push_back(mk_tick(16'h7777, 1'b1, 1'b0, 1'b1));
        tick_q.push_back(mk_tick(16'h7777, 1'b1, 1'b0, 1'b1));
        at_cnt(DV - 1);
        at_cnt(DV - 1);
        at_cnt(DV - 1);

        // P6: stage a word, then reset mid-period discards it.
        ack_q.push_back(mk_ack(2'b01, 2));
        send(0, 16'h9999, 2);
        at_cnt(8);
        rst_n = 1'b0;
        #1;
        reset_outputs_zero("rst1");
        repeat (3) @(posedge inclk);
        #1;
        rst_n = 1'b1;

        // Q0: first period after reset has nothing staged.
        tick_q.push_back(mk_tick(16'h0000, 1'b0, 1'b0, 1'b1));
        at_cnt(DV - GD);
        data0 = 16'hAAAA;
        data1 = 16'h5555;
        req   = 2'b11;
        // Q1..Q3: contention alternates, requester 0 first.
        ack_q.push_back(mk_ack(2'b01, 0));
        ack_q.push_back(mk_ack(2'b10, 0));
        ack_q.push_back(mk_ack(2'b01, 0));
        tick_q.push_back(mk_tick(16'hAAAA, 1'b0, 1'b1, 1'b0));
        tick_q.push_back(mk_tick(16'h5555, 1'b1, 1'b1, 1'b0));
        tick_q.push_back(mk_tick(16'hAAAA, 1'b0, 1'b1, 1'b0));
        at_cnt(1);
        at_cnt(1);
        at_cnt(1);
        req = 2'b00;
        at_cnt(DV - 1);
        repeat (3) @(posedge inclk);
        #1;

        chk("tick_q_drained", tick_q.size(), 32'd0);
        chk("ack_q_drained", ack_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/audio_sample_scheduler.md
AUDIO_SAMPLE_SCHEDULER -- requirements
Module: audio_sample_scheduler

Interface
REQ-001 Parameter WIDTH, default 16, sample word width in bits.
REQ-002 Parameter DIV, default 1042, inclk cycles per sample period (50 MHz / 48 kHz); legal range DIV >= GUARD+2.
REQ-003 Parameter GUARD, default 4, cycles before each tick during which no new word is accepted.
REQ-004 inclk  in  1  single fast system clock; all logic on posedge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req[1:0]  in  2  requester r holds a word for delivery; must stay high with stable data until ack[r].
REQ-007 data0, data1  in  WIDTH  sample word of requester 0 / 1.
REQ-008 ack[1:0]  out  2  one-cycle pulse, word of requester r accepted this cycle.
REQ-009 sample_tick  out  1  one-cycle pulse per sample period.
REQ-010 outdata  out  WIDTH  committed sample, stable for a full period.
REQ-011 out_src  out  1  index of requester that supplied outdata.
REQ-012 out_valid  out  1  one-cycle pulse coincident with a tick that committed a new word.
REQ-013 underrun  out  1  one-cycle pulse coincident with a tick that found no staged word.

Function
REQ-014 Counter cnt SHALL count 0..DIV-1 and wrap to 0; sample_tick SHALL be high exactly in the cycle cnt==DIV-1.
REQ-015 Guard window SHALL be cnt >= DIV-GUARD (GUARD cycles ending with the tick cycle inclusive); acceptance is open otherwise.
REQ-016 FSM states: S_OPEN (nothing staged, window open), S_STAGED (one word held), S_GUARD (window closed, nothing staged).
REQ-017 S_OPEN: if any req and window open, accept one word into staging register, pulse ack of the granted requester, go to S_STAGED; if window closes with nothing accepted, go to S_GUARD.
REQ-018 S_STAGED: no further acceptance; on tick copy staging to outdata, set out_src, pulse out_valid, go to S_OPEN.
REQ-019 S_GUARD: on tick pulse underrun, outdata/out_src unchanged, go to S_OPEN.
REQ-020 At most one word SHALL be accepted per sample period; ack SHALL never assert during the guard window.
REQ-021 A word accepted in the last open cycle (cnt==DIV-GUARD-1) SHALL be committed at the immediately following tick.
REQ-022 Arbitration SHALL be round-robin: single req wins; with both high, the requester not granted last wins; last-grant register updates only on an ack.
REQ-023 ack SHALL be registered-free of combinational paths from req to ack longer than one gate of arbitration (ack depends only on req and registered state in the same cycle).
REQ-024 outdata SHALL change only in tick cycles, guaranteeing downstream capture stability for DIV-1 cycles.
REQ-025 Staging register is not cleared on commit; its value is irrelevant outside S_STAGED.

Reset
REQ-026 While rst_n low: cnt=0, state=S_OPEN, last-grant=1 (requester 0 wins first contention), staging=0, outdata=0, out_src=0, ack=0, sample_tick=0, out_valid=0, underrun=0.
REQ-027 Reset asserted mid-period SHALL discard any staged, unacknowledged-by-commit word; a requester already acked loses that word (documented, not an error).
REQ-028 After rst_n deasserts, first tick SHALL occur DIV cycles later.

Structure
REQ-029 Shared package audio_sched_pkg SHALL hold the FSM state enum and default DIV/GUARD/WIDTH constants.
REQ-030 Sub-module sample_tick_gen (counter, tick, guard flag) SHALL be instantiated once; arbitration and FSM stay in the top.

Verification (DIV=16, GUARD=4, WIDTH=16)
REQ-031 req0 high at cnt=2 with data0=0x1234 -> ack[0] at cnt=2; at cnt=15 outdata=0x1234, out_src=0, out_valid=1.
REQ-032 req0 and req1 high continuously, data0=0xAAAA, data1=0x5555 -> commits alternate 0xAAAA, 0x5555, 0xAAAA; requester 0 first after reset.
REQ-033 req1 rises at cnt=12 (guard) -> no ack until cnt=0 of next period; that period's tick pulses underrun, outdata unchanged.
REQ-034 req0 rises at cnt=11 -> ack[0] at cnt=11, committed at cnt=15 same period.
REQ-035 No req for two periods -> two underrun pulses, out_valid never high, outdata retains last value.
REQ-036 rst_n low at cnt=8 while S_STAGED -> all outputs zero immediately; after release, no out_valid at first tick unless a new word is accepted.
